// File: rtl/glip_dbgnoc_bridge.sv
// Framed bridge between the 16-bit GLIP host FIFO stream and the multi-vchannel debug NoC.
// Host frames are {4'hF, vc, len} followed by len words; egress uses the same framing.
module glip_dbgnoc_bridge #(
    parameter int DBG_NOC_VCHANNELS = 2,
    parameter int BUF_DEPTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [15:0]                  fifo_in_data,
    input  logic                         fifo_in_valid,
    output logic                         fifo_in_ready,

    output logic [15:0]                  fifo_out_data,
    output logic                         fifo_out_valid,
    input  logic                         fifo_out_ready,

    output logic [17:0]                  dbgnoc_out_flit,
    output logic [DBG_NOC_VCHANNELS-1:0] dbgnoc_out_valid,
    input  logic [DBG_NOC_VCHANNELS-1:0] dbgnoc_out_ready,

    input  logic [17:0]                  dbgnoc_in_flit,
    input  logic [DBG_NOC_VCHANNELS-1:0] dbgnoc_in_valid,
    output logic [DBG_NOC_VCHANNELS-1:0] dbgnoc_in_ready,

    output logic                         err_sync,
    output logic                         err_vc,
    output logic                         err_trunc
);

    localparam int         VC     = DBG_NOC_VCHANNELS;
    localparam int         AW     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [7:0] DEPTH8 = 8'(BUF_DEPTH);

    localparam logic [1:0] I_HDR  = 2'd0;
    localparam logic [1:0] I_DATA = 2'd1;
    localparam logic [1:0] I_DISC = 2'd2;

    localparam logic [2:0] E_ARB   = 3'd0;
    localparam logic [2:0] E_FILL  = 3'd1;
    localparam logic [2:0] E_TRUNC = 3'd2;
    localparam logic [2:0] E_HDR   = 3'd3;
    localparam logic [2:0] E_DATA  = 3'd4;

    // Held low during reset so the host ready (combinational in I_HDR) also reads 0 then.
    logic run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Ingress: host -> NoC
    // ------------------------------------------------------------------
    logic [1:0] i_state, i_state_d;
    logic [3:0] i_vc, i_vc_d;
    logic [7:0] i_len, i_len_d;
    logic [7:0] i_rem, i_rem_d;
    logic       err_sync_d, err_vc_d;
    logic [1:0] i_type;
    logic       hdr_sync, hdr_vc_ok;
    logic [7:0] hdr_len;

    assign hdr_sync  = (fifo_in_data[15:12] == 4'hF);
    assign hdr_vc_ok = ({28'd0, fifo_in_data[11:8]} < 32'(VC));
    assign hdr_len   = fifo_in_data[7:0];

    always_comb begin
        i_state_d        = i_state;
        i_vc_d           = i_vc;
        i_len_d          = i_len;
        i_rem_d          = i_rem;
        err_sync_d       = 1'b0;
        err_vc_d         = 1'b0;
        fifo_in_ready    = 1'b0;
        dbgnoc_out_valid = '0;

        if (i_len == 8'd1) begin
            i_type = 2'b11;
        end else if (i_rem == i_len) begin
            i_type = 2'b01;
        end else if (i_rem == 8'd1) begin
            i_type = 2'b10;
        end else begin
            i_type = 2'b00;
        end
        dbgnoc_out_flit = {i_type, fifo_in_data};

        case (i_state)
            I_HDR: begin
                fifo_in_ready = run;
                if (fifo_in_valid && run) begin
                    if (!hdr_sync) begin
                        err_sync_d = 1'b1;
                    end else if (hdr_vc_ok && (hdr_len != 8'd0)) begin
                        i_vc_d    = fifo_in_data[11:8];
                        i_len_d   = hdr_len;
                        i_rem_d   = hdr_len;
                        i_state_d = I_DATA;
                    end else begin
                        err_vc_d = 1'b1;
                        if (hdr_len != 8'd0) begin
                            i_rem_d   = hdr_len;
                            i_state_d = I_DISC;
                        end
                    end
                end
            end
            I_DATA: begin
                for (int v = 0; v < VC; v++) begin
                    if (v == int'(i_vc)) begin
                        dbgnoc_out_valid[v] = fifo_in_valid;
                        fifo_in_ready       = dbgnoc_out_ready[v];
                    end
                end
                if (fifo_in_valid && fifo_in_ready) begin
                    i_rem_d = i_rem - 8'd1;
                    if (i_rem == 8'd1) begin
                        i_state_d = I_HDR;
                    end
                end
            end
            I_DISC: begin
                fifo_in_ready = 1'b1;
                if (fifo_in_valid) begin
                    i_rem_d = i_rem - 8'd1;
                    if (i_rem == 8'd1) begin
                        i_state_d = I_HDR;
                    end
                end
            end
            default: i_state_d = I_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state  <= I_HDR;
            i_vc     <= 4'd0;
            i_len    <= 8'd0;
            i_rem    <= 8'd0;
            err_sync <= 1'b0;
            err_vc   <= 1'b0;
        end else begin
            i_state  <= i_state_d;
            i_vc     <= i_vc_d;
            i_len    <= i_len_d;
            i_rem    <= i_rem_d;
            err_sync <= err_sync_d;
            err_vc   <= err_vc_d;
        end
    end

    // ------------------------------------------------------------------
    // Egress: NoC -> host, store-and-forward with round-robin arbitration
    // ------------------------------------------------------------------
    logic [2:0]  e_state, e_state_d;
    logic [3:0]  sel, sel_d;
    logic [3:0]  last, last_d;
    logic [7:0]  cnt, cnt_d;
    logic [7:0]  rd, rd_d;
    logic        err_trunc_d;
    logic        buf_we;
    logic [15:0] pkt_buf [BUF_DEPTH];

    logic        pick_found;
    logic [3:0]  pick;
    logic        sel_valid;
    logic        flit_term;
    int          idx;

    // Search begins one past the last grant so every vchannel gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick       = last;
        idx        = 0;
        for (int i = 1; i <= VC; i++) begin
            idx = (int'(last) + i) % VC;
            for (int v = 0; v < VC; v++) begin
                if (!pick_found && (v == idx) && dbgnoc_in_valid[v]) begin
                    pick_found = 1'b1;
                    pick       = idx[3:0];
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        for (int v = 0; v < VC; v++) begin
            if (v == int'(sel)) begin
                sel_valid = dbgnoc_in_valid[v];
            end
        end
    end

    // Both last (2'b10) and single (2'b11) end a packet.
    assign flit_term = dbgnoc_in_flit[17];

    always_comb begin
        e_state_d       = e_state;
        sel_d           = sel;
        last_d          = last;
        cnt_d           = cnt;
        rd_d            = rd;
        err_trunc_d     = 1'b0;
        buf_we          = 1'b0;
        dbgnoc_in_ready = '0;
        fifo_out_valid  = 1'b0;
        fifo_out_data   = pkt_buf[rd[AW-1:0]];

        case (e_state)
            E_ARB: begin
                if (pick_found) begin
                    sel_d     = pick;
                    cnt_d     = 8'd0;
                    e_state_d = E_FILL;
                end
            end
            E_FILL: begin
                for (int v = 0; v < VC; v++) begin
                    if (v == int'(sel)) begin
                        dbgnoc_in_ready[v] = 1'b1;
                    end
                end
                if (sel_valid) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt + 8'd1;
                    if (flit_term) begin
                        e_state_d = E_HDR;
                    end else if (cnt_d == DEPTH8) begin
                        e_state_d   = E_TRUNC;
                        err_trunc_d = 1'b1;
                    end
                end
            end
            E_TRUNC: begin
                for (int v = 0; v < VC; v++) begin
                    if (v == int'(sel)) begin
                        dbgnoc_in_ready[v] = 1'b1;
                    end
                end
                if (sel_valid && flit_term) begin
                    e_state_d = E_HDR;
                end
            end
            E_HDR: begin
                fifo_out_valid = 1'b1;
                fifo_out_data  = {4'hF, sel, cnt};
                if (fifo_out_ready) begin
                    rd_d      = 8'd0;
                    e_state_d = E_DATA;
                end
            end
            E_DATA: begin
                fifo_out_valid = 1'b1;
                if (fifo_out_ready) begin
                    if (rd == cnt - 8'd1) begin
                        last_d    = sel;
                        e_state_d = E_ARB;
                    end else begin
                        rd_d = rd + 8'd1;
                    end
                end
            end
            default: e_state_d = E_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_state   <= E_ARB;
            sel       <= 4'd0;
            last      <= 4'(VC - 1);
            cnt       <= 8'd0;
            rd        <= 8'd0;
            err_trunc <= 1'b0;
        end else begin
            e_state   <= e_state_d;
            sel       <= sel_d;
            last      <= last_d;
            cnt       <= cnt_d;
            rd        <= rd_d;
            err_trunc <= err_trunc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            pkt_buf[cnt[AW-1:0]] <= dbgnoc_in_flit[15:0];
        end
    end

endmodule

// File: tb/tb_glip_dbgnoc_bridge.sv
// Scoreboard bench for glip_dbgnoc_bridge: directed framing cases plus randomized traffic
// in both directions, checked against a frame-level reference model.
module tb_glip_dbgnoc_bridge;

    localparam int VCH   = 2;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [15:0]    fifo_in_data;
    logic           fifo_in_valid;
    logic           fifo_in_ready;
    logic [15:0]    fifo_out_data;
    logic           fifo_out_valid;
    logic           fifo_out_ready;
    logic [17:0]    dbgnoc_out_flit;
    logic [VCH-1:0] dbgnoc_out_valid;
    logic [VCH-1:0] dbgnoc_out_ready;
    logic [17:0]    dbgnoc_in_flit;
    logic [VCH-1:0] dbgnoc_in_valid;
    logic [VCH-1:0] dbgnoc_in_ready;
    logic           err_sync, err_vc, err_trunc;

    always #5 clk = ~clk;

    glip_dbgnoc_bridge #(
        .DBG_NOC_VCHANNELS(VCH),
        .BUF_DEPTH        (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_in_data    (fifo_in_data),
        .fifo_in_valid   (fifo_in_valid),
        .fifo_in_ready   (fifo_in_ready),
        .fifo_out_data   (fifo_out_data),
        .fifo_out_valid  (fifo_out_valid),
        .fifo_out_ready  (fifo_out_ready),
        .dbgnoc_out_flit (dbgnoc_out_flit),
        .dbgnoc_out_valid(dbgnoc_out_valid),
        .dbgnoc_out_ready(dbgnoc_out_ready),
        .dbgnoc_in_flit  (dbgnoc_in_flit),
        .dbgnoc_in_valid (dbgnoc_in_valid),
        .dbgnoc_in_ready (dbgnoc_in_ready),
        .err_sync        (err_sync),
        .err_vc          (err_vc),
        .err_trunc       (err_trunc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: expected NoC flits {vc, type, data}, expected host words per vc.
    logic [21:0] exp_noc [$];
    logic [15:0] exp_eg0 [$];
    logic [15:0] exp_eg1 [$];
    logic [17:0] src_q0  [$];
    logic [17:0] src_q1  [$];
    int exp_sync = 0, exp_vc = 0, exp_trunc = 0;
    int got_sync = 0, got_vc = 0, got_trunc = 0;

    int rdy_mode    = 1;  // 0 random, 1 all high, 2 all low
    int oready_mode = 1;  // 0 random, 1 high
    int eg_gap      = 0;
    int alt_chk     = 0;
    int alt_cnt     = 0;
    int alt_prev    = 0;
    logic [7:0] mon_rem = 8'd0;
    logic [3:0] mon_v   = 4'd0;

    logic [VCH-1:0] src_valid;
    logic [17:0]    src_flit0, src_flit1;

    assign dbgnoc_in_valid = src_valid;
    assign dbgnoc_in_flit  = dbgnoc_in_ready[1] ? src_flit1 : src_flit0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h, required nothing", name, act);
    endtask

    // Sink readiness for both directions, changed just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       dbgnoc_out_ready = VCH'($urandom_range(0, 3));
                1:       dbgnoc_out_ready = '1;
                default: dbgnoc_out_ready = '0;
            endcase
            fifo_out_ready = (oready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // NoC source: one flit queue per vc; a flit is held until accepted.
    initial begin
        logic [VCH-1:0] acc;
        src_valid = '0;
        src_flit0 = '0;
        src_flit1 = '0;
        forever begin
            @(negedge clk);
            acc = src_valid & dbgnoc_in_ready;
            @(posedge clk);
            #1;
            if (acc[0]) void'(src_q0.pop_front());
            if (acc[1]) void'(src_q1.pop_front());
            if (!(src_valid[0] && !acc[0]))
                src_valid[0] = (src_q0.size() != 0) && (eg_gap == 0 || $urandom_range(0, 3) != 0);
            if (!(src_valid[1] && !acc[1]))
                src_valid[1] = (src_q1.size() != 0) && (eg_gap == 0 || $urandom_range(0, 3) != 0);
            if (src_valid[0]) src_flit0 = src_q0[0];
            if (src_valid[1]) src_flit1 = src_q1[0];
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [21:0] e;
        logic [15:0] w;
        logic        got;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dbgnoc_out_valid != '0)
                    check("noc_onehot", 32'($countones(dbgnoc_out_valid)), 1);
                for (int v = 0; v < VCH; v++) begin
                    if (dbgnoc_out_valid[v] && dbgnoc_out_ready[v]) begin
                        if (exp_noc.size() == 0) begin
                            fail_now("noc_unexpected", {10'd0, 4'(v), dbgnoc_out_flit});
                        end else begin
                            e = exp_noc.pop_front();
                            check("noc_flit", {10'd0, 4'(v), dbgnoc_out_flit}, {10'd0, e});
                        end
                    end
                end
                if (err_sync)  got_sync++;
                if (err_vc)    got_vc++;
                if (err_trunc) got_trunc++;
                if (fifo_out_valid && fifo_out_ready) begin
                    got = 1'b0;
                    w   = 16'd0;
                    if (mon_rem == 8'd0) begin
                        if (fifo_out_data[11:8] == 4'd0 && exp_eg0.size() != 0) begin
                            w = exp_eg0.pop_front(); got = 1'b1;
                        end else if (fifo_out_data[11:8] == 4'd1 && exp_eg1.size() != 0) begin
                            w = exp_eg1.pop_front(); got = 1'b1;
                        end
                        if (!got) begin
                            fail_now("eg_unexpected_hdr", fifo_out_data);
                        end else begin
                            check("eg_hdr", fifo_out_data, w);
                            mon_v   = fifo_out_data[11:8];
                            mon_rem = fifo_out_data[7:0];
                            if (alt_chk != 0) begin
                                check("rr_alternate", fifo_out_data[11:8],
                                      (alt_cnt == 0) ? 0 : 1 - alt_prev);
                                alt_prev = int'(fifo_out_data[11:8]);
                                alt_cnt++;
                            end
                        end
                    end else begin
                        if (mon_v == 4'd0 && exp_eg0.size() != 0) begin
                            w = exp_eg0.pop_front(); got = 1'b1;
                        end else if (mon_v == 4'd1 && exp_eg1.size() != 0) begin
                            w = exp_eg1.pop_front(); got = 1'b1;
                        end
                        if (!got) fail_now("eg_unexpected_data", fifo_out_data);
                        else      check("eg_data", fifo_out_data, w);
                        mon_rem = mon_rem - 8'd1;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [15:0] w, output int cyc);
        fifo_in_data  = w;
        fifo_in_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!fifo_in_ready && cyc < 500);
        if (!fifo_in_ready) fail_now("host_word_timeout", w);
        @(posedge clk);
        #1;
        fifo_in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] w);
        int c;
        send_word(w, c);
    endtask

    function automatic logic [1:0] ftype(input int i, input int n);
        if (n == 1)     return 2'b11;
        if (i == 0)     return 2'b01;
        if (i == n - 1) return 2'b10;
        return 2'b00;
    endfunction

    // Random host frame: garbage word, bad vc, zero length or a good packet.
    task automatic host_frame();
        int          kind, n;
        logic [3:0]  v;
        logic [15:0] w;
        logic [15:0] d [8];
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h7;
            exp_sync++;
            send(w);
        end else if (kind == 1) begin
            v = 4'($urandom_range(VCH, 15));
            n = $urandom_range(1, 3);
            exp_vc++;
            send({4'hF, v, 8'(n)});
            for (int i = 0; i < n; i++) send(16'($urandom));
        end else if (kind == 2) begin
            exp_vc++;
            send({4'hF, 4'($urandom_range(0, VCH - 1)), 8'd0});
        end else begin
            v = 4'($urandom_range(0, VCH - 1));
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                d[i] = 16'($urandom);
                exp_noc.push_back({v, ftype(i, n), d[i]});
            end
            send({4'hF, v, 8'(n)});
            for (int i = 0; i < n; i++) begin
                send(d[i]);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
    endtask

    // Queue an n-flit NoC packet on vc v; the host should see at most DEPTH words of it.
    task automatic eg_pkt(input int v, input int n, input bit mid);
        int          len;
        logic [1:0]  t;
        logic [15:0] d;
        logic [15:0] hdr;
        len = (n > DEPTH) ? DEPTH : n;
        hdr = {4'hF, 4'(v), 8'(len)};
        if (v == 0) exp_eg0.push_back(hdr); else exp_eg1.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            t = ftype(i, n);
            if (mid && i > 0 && i < n - 1) t = 2'b01;
            if (v == 0) src_q0.push_back({t, d}); else src_q1.push_back({t, d});
            if (i < len) begin
                if (v == 0) exp_eg0.push_back(d); else exp_eg1.push_back(d);
            end
        end
        if (n > DEPTH) exp_trunc++;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_noc.size() != 0 || exp_eg0.size() != 0 || exp_eg1.size() != 0 ||
                src_q0.size() != 0 || src_q1.size() != 0 || mon_rem != 8'd0) && k < 4000) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({name, "_drain_timeout"}, 32'(k >= 4000), 0);
    endtask

    task automatic check_errs(input string name);
        check({name, "_err_sync"},  got_sync,  exp_sync);
        check({name, "_err_vc"},    got_vc,    exp_vc);
        check({name, "_err_trunc"}, got_trunc, exp_trunc);
    endtask

    initial begin
        int c, tot;
        rst           = 1'b1;
        fifo_in_data  = 16'd0;
        fifo_in_valid = 1'b0;
        #12;
        check("rst_outputs", {fifo_in_ready, dbgnoc_out_valid, dbgnoc_in_ready, fifo_out_valid,
                              err_sync, err_vc, err_trunc}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("ready_after_rst", fifo_in_ready, 1);

        // Directed ingress cases with NoC ready held high.
        exp_noc.push_back({4'd1, 2'b01, 16'hAAAA});
        exp_noc.push_back({4'd1, 2'b00, 16'hBBBB});
        exp_noc.push_back({4'd1, 2'b10, 16'hCCCC});
        tot = 0;
        send_word(16'hF103, c); tot += c;
        send_word(16'hAAAA, c); tot += c;
        send_word(16'hBBBB, c); tot += c;
        send_word(16'hCCCC, c); tot += c;
        check("ingress_consecutive_cycles", tot, 4);

        exp_sync += 2;
        exp_noc.push_back({4'd0, 2'b11, 16'h00EE});
        send(16'h1234); send(16'h5678); send(16'hF001); send(16'h00EE);

        exp_vc++;
        send(16'hF502); send(16'h1111); send(16'h2222);
        exp_vc++;
        send(16'hF000);
        exp_noc.push_back({4'd1, 2'b11, 16'h0055});
        send(16'hF101); send(16'h0055);
        drain("ingress_directed");
        check_errs("ingress_directed");

        // Both vchannels offer 2-flit packets continuously: grants must alternate from vc0.
        alt_chk = 1;
        for (int i = 0; i < 3; i++) begin
            eg_pkt(0, 2, 1'b0);
            eg_pkt(1, 2, 1'b0);
        end
        drain("rr");
        alt_chk = 0;
        check("rr_grant_count", alt_cnt, 6);

        // Over-long packet is truncated to DEPTH words; the following packet is intact.
        eg_pkt(0, 6, 1'b0);
        eg_pkt(0, 2, 1'b0);
        drain("trunc");
        check_errs("trunc");

        // Randomized traffic in both directions with random back-pressure.
        rdy_mode    = 0;
        oready_mode = 0;
        eg_gap      = 1;
        for (int i = 0; i < 16; i++) begin
            eg_pkt(0, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
            eg_pkt(1, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 60; i++) host_frame();
        drain("random");
        check_errs("random");

        // Reset in the middle of an ingress packet.
        rdy_mode    = 1;
        oready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        exp_noc.push_back({4'd1, 2'b01, 16'hAAAA});
        send(16'hF103);
        send(16'hAAAA);
        rdy_mode = 2;
        @(posedge clk);
        #2;
        fifo_in_data  = 16'hBBBB;
        fifo_in_valid = 1'b1;
        @(negedge clk);
        check("rst_pre_valid", dbgnoc_out_valid, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_drop", {fifo_in_ready, dbgnoc_out_valid, dbgnoc_in_ready, fifo_out_valid}, 0);
        exp_noc.delete();
        fifo_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        exp_noc.push_back({4'd0, 2'b11, 16'h0042});
        send(16'hF001);
        send(16'h0042);
        drain("post_rst");
        check_errs("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/glip_dbgnoc_bridge.md
Name: glip_dbgnoc_bridge

Overview:
- Framed bridge between the 16-bit GLIP host FIFO stream and the multi-vchannel 16-bit debug NoC; parametrised successor of the fixed single-config-channel FIFO/debug interface.
- Host->NoC: every packet is preceded by a sync/length word, so the bridge can resynchronise after a communication reset mid-stream (hot-attach).
- NoC->host: store-and-forward per packet, round-robin over all vchannels, emitted with the same framing.

Parameters:
DBG_NOC_VCHANNELS, 2, number of debug NoC vchannels (1..16)
BUF_DEPTH, 16, egress packet buffer depth in flits (2..255)

Ports:
clk  in  1  bridge clock (clk_dbg domain)
rst  in  1  reset, asynchronous, active-high
fifo_in_data  in  16  word from host (GLIP fifo_out_data)
fifo_in_valid  in  1  host word valid
fifo_in_ready  out  1  host word accepted
fifo_out_data  out  16  word to host
fifo_out_valid  out  1  word to host valid
fifo_out_ready  in  1  host accepts word
dbgnoc_out_flit  out  18  flit to NoC, {type[1:0], data[15:0]}
dbgnoc_out_valid  out  DBG_NOC_VCHANNELS  per-vchannel valid
dbgnoc_out_ready  in  DBG_NOC_VCHANNELS  per-vchannel ready
dbgnoc_in_flit  in  18  flit from NoC
dbgnoc_in_valid  in  DBG_NOC_VCHANNELS  per-vchannel valid
dbgnoc_in_ready  out  DBG_NOC_VCHANNELS  per-vchannel ready
err_sync  out  1  1-cycle pulse: non-sync word dropped in ingress header state
err_vc  out  1  1-cycle pulse: ingress packet discarded, vc >= DBG_NOC_VCHANNELS or len=0
err_trunc  out  1  1-cycle pulse: egress packet exceeded BUF_DEPTH

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high on rst. Reset drives all FSMs to idle state, all counters to 0, and all outputs (valid, ready, err_*) to 0. Round-robin pointer resets so that vc0 has highest priority first.
- Frame word: [15:12]=4'hF sync, [11:8]=vc, [7:0]=len in flits. Flit types: 2'b01 header, 2'b00 payload, 2'b10 last, 2'b11 single.

Ingress FSM (states I_HDR, I_DATA, I_DISC):
- I_HDR:
  - fifo_in_ready=1.
  - Word with [15:12]!=4'hF: dropped, err_sync pulses, stay in I_HDR.
  - Valid sync word with vc<VCHANNELS and len>0: latch vc and len, go to I_DATA.
  - Otherwise: pulse err_vc. If len>0, go to I_DISC; if len=0, stay in I_HDR.
- I_DATA:
  - Zero-latency combinational path: dbgnoc_out_valid[vc]=fifo_in_valid, fifo_in_ready=dbgnoc_out_ready[vc], all other valid bits 0.
  - Type: single if len=1; otherwise header for the first flit, last for the final flit, payload in between.
  - Remaining count decrements per accepted word; after the final flit return to I_HDR.
- I_DISC: fifo_in_ready=1, consume len words, then return to I_HDR.

Egress FSM (states E_ARB, E_FILL, E_TRUNC, E_HDR, E_DATA):
- E_ARB:
  - Registered round-robin pick; search starts at (last grant + 1) over dbgnoc_in_valid.
  - Takes 1 cycle; no ready asserted in this state.
  - Go to E_FILL with sel latched.
- E_FILL:
  - dbgnoc_in_ready[sel]=1, all others 0.
  - Each accepted flit writes data[15:0] to buf[cnt], cnt++.
  - On last or single type: go to E_HDR.
  - If cnt reaches BUF_DEPTH on a non-terminal flit: go to E_TRUNC.
- E_TRUNC: ready[sel]=1; drop flits through the next last/single flit; pulse err_trunc on entry; then go to E_HDR with len=BUF_DEPTH.
- E_HDR: fifo_out_valid=1, data={4'hF, sel[3:0], cnt[7:0]}; on fifo_out_ready go to E_DATA, rd=0.
- E_DATA: fifo_out_data=buf[rd]; on each handshake rd++; after rd=cnt-1, go to E_ARB and update the rr pointer.
- Egress ignores type on non-terminal flits; a header-type flit mid-packet is stored as data.
- Ingress and egress are fully independent and may be active in the same cycle.
- Reset mid-packet: partial frames are abandoned with no flush. The host re-synchronises by sending any non-F words, then a sync word.

Test Plan:
- Host sends F103,AAAA,BBBB,CCCC with ready held high -> vc1 carries flits 1AAAA, 0BBBB, 2CCCC on consecutive cycles; vc0 valid stays 0.
- Host sends 1234,5678,F001,00EE -> err_sync pulses twice; vc0 receives one flit, 300EE.
- Host sends F502,1111,2222 with VCHANNELS=2 -> err_vc pulses once, both words consumed, no NoC valid; F000 -> err_vc pulses, FSM stays in I_HDR.
- vc0 and vc1 both offer 2-flit packets continuously -> host stream F002,d,d,F102,d,d,F002,...; grants strictly alternate.
- BUF_DEPTH=4, vc0 sends a 6-flit packet -> err_trunc pulses once; host receives F004 plus the first 4 data words; remaining flits consumed; next packet is framed correctly.
- rst asserted during I_DATA after 1 of 3 flits -> all valid/ready drop asynchronously; after release, F001,0042 yields single flit 30042.
